// File: rtl/pll_rst_pkg.sv
// Shared types and default constants for the PLL lock / reset sequencer.
// State encoding is visible on state_o, so it is fixed here.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_RESET_HOLD_CYCLES  = 16;
  localparam int DEF_LOSS_CNT_W         = 8;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level.
// Cleared asynchronously so the synced level reads 0 while in reset.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Turns the asynchronous PLL lock flag into a qualified, held system reset.
// Lock loss in RUN drops reset on the next FSM edge and bumps a saturating counter.
module pll_lock_reset_seq
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int LOSS_CNT_W         = DEF_LOSS_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_lock,
  input  logic                  soft_rst_req,
  output logic                  sys_rst_n,
  output logic                  lock_synced,
  output logic [1:0]            state_o,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int CW = max_i(1,
    $clog2(max_i(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)));
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HLD_LAST = CW'(RESET_HOLD_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic                    rst_q, rst_d;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (pll_lock),
    .q_o  (lock_synced)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      loss_q  <= '0;
      rst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
      rst_q   <= rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_synced) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!lock_synced) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (!lock_synced) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == HLD_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        // lock loss takes priority over a coincident soft request
        if (!lock_synced) begin
          state_d = WAIT_LOCK;
          if (loss_q != '1) begin
            loss_d = loss_q + LOSS_CNT_W'(1);
          end
        end else if (soft_rst_req) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_comb begin
    rst_d = (state_d == RUN);
  end

  assign sys_rst_n  = rst_q;
  assign state_o    = state_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq with short qualification windows.
// Outputs are sampled 1 time unit after each rising edge.
module tb_pll_lock_reset_seq;
  import pll_rst_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       soft_rst_req;
  logic       sys_rst_n;
  logic       lock_synced;
  logic [1:0] state_o;
  logic [1:0] loss_count;

  int checks;
  int errors;

  pll_lock_reset_seq #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .RESET_HOLD_CYCLES (4),
    .LOSS_CNT_W        (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .soft_rst_req(soft_rst_req),
    .sys_rst_n   (sys_rst_n),
    .lock_synced (lock_synced),
    .state_o     (state_o),
    .loss_count  (loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    pll_lock     = 1'b0;
    soft_rst_req = 1'b0;

    // 1: reset state, then power-up qualification
    #3;
    chk("rst_sys", 8'(sys_rst_n), 8'd0);
    chk("rst_state", 8'(state_o), 8'(WAIT_LOCK));
    chk("rst_loss", 8'(loss_count), 8'd0);
    chk("rst_sync", 8'(lock_synced), 8'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    pll_lock = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      step();
      chk($sformatf("t1_sys_e%0d", e), 8'(sys_rst_n), 8'(e == 15));
      if (e == 1) chk("t1_sync_e1", 8'(lock_synced), 8'd0);
      if (e == 2) chk("t1_sync_e2", 8'(lock_synced), 8'd1);
      if (e == 3) chk("t1_stable", 8'(state_o), 8'(STABLE));
      if (e == 11) chk("t1_hold", 8'(state_o), 8'(HOLD));
    end
    chk("t1_run", 8'(state_o), 8'(RUN));

    // 2: one-cycle lock drop in RUN, then re-qualify
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    step();
    chk("t2_sys_e2", 8'(sys_rst_n), 8'd1);
    step();
    chk("t2_sys_e3", 8'(sys_rst_n), 8'd0);
    chk("t2_state_e3", 8'(state_o), 8'(WAIT_LOCK));
    chk("t2_loss", 8'(loss_count), 8'd1);
    for (int e = 4; e <= 16; e++) begin
      step();
      chk($sformatf("t2_sys_e%0d", e), 8'(sys_rst_n), 8'(e == 16));
    end
    chk("t2_run", 8'(state_o), 8'(RUN));

    // 4: soft reset from RUN; second pulse during HOLD is ignored
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    chk("t4_sys_e1", 8'(sys_rst_n), 8'd0);
    chk("t4_hold", 8'(state_o), 8'(HOLD));
    step();
    chk("t4_sys_e2", 8'(sys_rst_n), 8'd0);
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    chk("t4_sys_e3", 8'(sys_rst_n), 8'd0);
    step();
    chk("t4_sys_e4", 8'(sys_rst_n), 8'd0);
    step();
    chk("t4_sys_e5", 8'(sys_rst_n), 8'd1);
    chk("t4_run", 8'(state_o), 8'(RUN));
    chk("t4_loss", 8'(loss_count), 8'd1);

    // 3: leave RUN by loss, then glitch lock during STABLE at cnt=5
    pll_lock = 1'b0;
    repeat (3) step();
    chk("t3_wait", 8'(state_o), 8'(WAIT_LOCK));
    chk("t3_loss_a", 8'(loss_count), 8'd2);
    pll_lock = 1'b1;
    repeat (8) step();
    chk("t3_stable", 8'(state_o), 8'(STABLE));
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    step();
    chk("t3_still_stb", 8'(state_o), 8'(STABLE));
    step();
    chk("t3_restart", 8'(state_o), 8'(WAIT_LOCK));
    for (int r = 12; r <= 24; r++) begin
      step();
      chk($sformatf("t3_sys_r%0d", r), 8'(sys_rst_n), 8'(r == 24));
    end
    chk("t3_loss_b", 8'(loss_count), 8'd2);

    // 5: lock loss coincident with soft request, then saturation
    pll_lock = 1'b0;
    step();
    step();
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    chk("t5_state", 8'(state_o), 8'(WAIT_LOCK));
    chk("t5_loss", 8'(loss_count), 8'd3);
    chk("t5_sys", 8'(sys_rst_n), 8'd0);
    for (int k = 0; k < 4; k++) begin
      pll_lock = 1'b1;
      repeat (15) step();
      chk($sformatf("t5_up%0d", k), 8'(sys_rst_n), 8'd1);
      pll_lock = 1'b0;
      repeat (3) step();
      chk($sformatf("t5_sat%0d", k), 8'(loss_count), 8'd3);
    end

    // 6: asynchronous reset in the middle of HOLD
    pll_lock = 1'b1;
    repeat (12) step();
    chk("t6_hold", 8'(state_o), 8'(HOLD));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_sys", 8'(sys_rst_n), 8'd0);
    chk("t6_loss", 8'(loss_count), 8'd0);
    chk("t6_state", 8'(state_o), 8'(WAIT_LOCK));
    chk("t6_sync", 8'(lock_synced), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
